// File: rtl/nic_defs.sv
// nic_ctrl shared definitions: register map,
// packet width and virtual-channel bit position.
package nic_defs;

    localparam int PKT_W = 64;
    localparam int VC_BIT = 0;

    localparam logic [1:0] NIC_IN_BUF   = 2'b00;
    localparam logic [1:0] NIC_IN_STAT  = 2'b01;
    localparam logic [1:0] NIC_OUT_BUF  = 2'b10;
    localparam logic [1:0] NIC_OUT_STAT = 2'b11;

endpackage

// File: rtl/nic_fifo.sv
// nic_fifo: synchronous packet FIFO with head-of-queue
// read data; storage is cleared by reset.
module nic_fifo
    import nic_defs::*;
#(
    parameter int DEPTH = 2,
    parameter int PKT_W = nic_defs::PKT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [0:PKT_W-1] wdata,
    output logic [0:PKT_W-1] rdata,
    output logic             full,
    output logic             empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [PW-1:0] P_ONE = PW'(1);
    localparam logic [CW-1:0] C_ONE = CW'(1);
    localparam logic [CW-1:0] C_FULL = CW'(DEPTH);

    logic [0:PKT_W-1] r_mem [0:DEPTH-1];
    logic [PW-1:0]    r_rptr;
    logic [PW-1:0]    r_wptr;
    logic [CW-1:0]    r_count;
    logic             w_push;
    logic             w_pop;

    assign full  = (r_count == C_FULL);
    assign empty = (r_count == '0);
    assign rdata = r_mem[r_rptr];

    // Accept only legal operations; push and pop may coincide.
    assign w_push = push & ~full;
    assign w_pop  = pop & ~empty;

    // Storage, pointers and occupancy; pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_rptr  <= '0;
            r_wptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wptr] <= wdata;
                r_wptr        <= r_wptr + P_ONE;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + P_ONE;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + C_ONE;
                2'b01:   r_count <= r_count - C_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/nic_ctrl.sv
// nic_ctrl: processor register window, polarity-gated
// injection and router handshake glue around two FIFOs.
module nic_ctrl
    import nic_defs::*;
#(
    parameter int DEPTH = 2,
    parameter int PKT_W = nic_defs::PKT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             nicEn,
    input  logic             nicWrEn,
    input  logic [0:1]       addr_nic,
    input  logic [0:PKT_W-1] din_nic,
    output logic [0:PKT_W-1] dout_nic,
    output logic             net_si,
    input  logic             net_ri,
    output logic [0:PKT_W-1] net_do,
    input  logic             net_so,
    output logic             net_ro,
    input  logic [0:PKT_W-1] net_di,
    input  logic             net_polarity
);

    logic             w_rd;
    logic             w_wr;
    logic             w_in_push;
    logic             w_in_pop;
    logic [0:PKT_W-1] w_in_head;
    logic             w_in_full;
    logic             w_in_empty;
    logic             w_out_push;
    logic             w_out_pop;
    logic [0:PKT_W-1] w_out_head;
    logic             w_out_full;
    logic             w_out_empty;

    assign w_rd = nicEn & ~nicWrEn;
    assign w_wr = nicEn & nicWrEn;

    assign net_ro    = ~w_in_full;
    assign w_in_push = net_so & ~w_in_full;
    assign w_in_pop  = w_rd & (addr_nic == NIC_IN_BUF);

    assign w_out_push = w_wr & (addr_nic == NIC_OUT_BUF) & ~w_out_full;
    assign net_do     = w_out_head;
    assign net_si     = ~w_out_empty
                      & (w_out_head[VC_BIT] == net_polarity);
    assign w_out_pop  = net_si & net_ri;

    nic_fifo #(
        .DEPTH (DEPTH),
        .PKT_W (PKT_W)
    ) u_in_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (w_in_push),
        .pop   (w_in_pop),
        .wdata (net_di),
        .rdata (w_in_head),
        .full  (w_in_full),
        .empty (w_in_empty)
    );

    nic_fifo #(
        .DEPTH (DEPTH),
        .PKT_W (PKT_W)
    ) u_out_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (w_out_push),
        .pop   (w_out_pop),
        .wdata (din_nic),
        .rdata (w_out_head),
        .full  (w_out_full),
        .empty (w_out_empty)
    );

    // Read mux: status flag sits in the last bit of the word.
    always_comb begin
        dout_nic = '0;
        if (w_rd) begin
            unique case (addr_nic)
                NIC_IN_BUF:   dout_nic = w_in_empty ? '0 : w_in_head;
                NIC_IN_STAT:  dout_nic[PKT_W-1] = ~w_in_empty;
                NIC_OUT_BUF:  dout_nic = '0;
                NIC_OUT_STAT: dout_nic[PKT_W-1] = w_out_full;
            endcase
        end
    end

endmodule

// File: tb/tb_nic_ctrl.sv
// tb_nic_ctrl: directed vectors for nic_ctrl with
// hand-computed expectations.
module tb_nic_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        nicEn;
    logic        nicWrEn;
    logic [0:1]  addr_nic;
    logic [0:63] din_nic;
    logic [0:63] dout_nic;
    logic        net_si;
    logic        net_ri;
    logic [0:63] net_do;
    logic        net_so;
    logic        net_ro;
    logic [0:63] net_di;
    logic        net_polarity;

    int n_vec = 0;
    int n_err = 0;

    nic_ctrl #(
        .DEPTH (2),
        .PKT_W (64)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .nicEn        (nicEn),
        .nicWrEn      (nicWrEn),
        .addr_nic     (addr_nic),
        .din_nic      (din_nic),
        .dout_nic     (dout_nic),
        .net_si       (net_si),
        .net_ri       (net_ri),
        .net_do       (net_do),
        .net_so       (net_so),
        .net_ro       (net_ro),
        .net_di       (net_di),
        .net_polarity (net_polarity)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic peek(input logic [1:0] a,
                        input string tag,
                        input logic [63:0] exp);
        nicEn = 1'b1; nicWrEn = 1'b0; addr_nic = a;
        #1;
        chk(tag, dout_nic, exp);
        nicEn = 1'b0;
        #1;
    endtask

    task automatic pop_chk(input string tag,
                           input logic [63:0] exp);
        nicEn = 1'b1; nicWrEn = 1'b0; addr_nic = 2'b00;
        #1;
        chk(tag, dout_nic, exp);
        tick();
        nicEn = 1'b0;
    endtask

    task automatic wr(input logic [1:0] a,
                      input logic [63:0] d);
        nicEn = 1'b1; nicWrEn = 1'b1; addr_nic = a; din_nic = d;
        tick();
        nicEn = 1'b0; nicWrEn = 1'b0;
    endtask

    initial begin
        reset = 1'b1; nicEn = 1'b0; nicWrEn = 1'b0;
        addr_nic = 2'b00; din_nic = '0; net_ri = 1'b0;
        net_so = 1'b0; net_di = '0; net_polarity = 1'b0;
        tick(); tick();
        reset = 1'b0;
        tick();

        chk("rst_ro", 64'(net_ro), 64'd1);
        chk("rst_si", 64'(net_si), 64'd0);
        chk("rst_do", net_do, 64'h0);
        peek(2'b01, "rst_in_stat", 64'h0);
        peek(2'b11, "rst_out_stat", 64'h0);
        nicEn = 1'b1; nicWrEn = 1'b1; addr_nic = 2'b01; #1;
        chk("dout_on_write", dout_nic, 64'h0);
        nicEn = 1'b0; nicWrEn = 1'b0; #1;

        // vc=0 packet sent next cycle
        net_polarity = 1'b0; net_ri = 1'b1;
        wr(2'b10, 64'h0000_0000_0000_00AA);
        chk("aa_si", 64'(net_si), 64'd1);
        chk("aa_do", net_do, 64'h0000_0000_0000_00AA);
        tick();
        chk("aa_gone_si", 64'(net_si), 64'd0);
        peek(2'b11, "aa_out_stat", 64'h0);

        // vc=1 packet blocked until polarity matches
        wr(2'b10, 64'h8000_0000_0000_0001);
        for (int i = 0; i < 5; i++) begin
            chk("vc1_blocked", 64'(net_si), 64'd0);
            tick();
        end
        net_polarity = 1'b1; #1;
        chk("vc1_si", 64'(net_si), 64'd1);
        chk("vc1_do", net_do, 64'h8000_0000_0000_0001);
        tick();
        chk("vc1_sent", 64'(net_si), 64'd0);
        net_polarity = 1'b0;

        // receive path fills input FIFO
        net_so = 1'b1; net_di = 64'h11;
        tick();
        peek(2'b01, "rx_stat1", 64'h1);
        net_di = 64'h22;
        tick();
        net_so = 1'b0;
        chk("rx_ro_full", 64'(net_ro), 64'd0);
        pop_chk("rx_pop1", 64'h11);
        chk("rx_ro_back", 64'(net_ro), 64'd1);
        pop_chk("rx_pop2", 64'h22);
        pop_chk("rx_pop_empty", 64'h0);
        peek(2'b01, "rx_stat0", 64'h0);

        // full output FIFO drops the extra write
        net_ri = 1'b0;
        wr(2'b10, 64'h0000_0000_0000_00A1);
        wr(2'b10, 64'h0000_0000_0000_00A2);
        peek(2'b11, "full_stat", 64'h1);
        wr(2'b10, 64'h33);
        peek(2'b11, "full_stat2", 64'h1);
        net_ri = 1'b1; #1;
        chk("drain_do1", net_do, 64'h0000_0000_0000_00A1);
        tick();
        chk("drain_si2", 64'(net_si), 64'd1);
        chk("drain_do2", net_do, 64'h0000_0000_0000_00A2);
        tick();
        chk("drain_done", 64'(net_si), 64'd0);
        peek(2'b11, "drain_stat", 64'h0);

        // write racing a send while full is still dropped
        net_ri = 1'b0;
        wr(2'b10, 64'h0000_0000_0000_00B1);
        wr(2'b10, 64'h0000_0000_0000_00B2);
        net_ri = 1'b1;
        wr(2'b10, 64'h33);
        chk("race_do", net_do, 64'h0000_0000_0000_00B2);
        tick();
        chk("race_dropped", 64'(net_si), 64'd0);

        // reset discards buffered packets
        net_ri = 1'b0;
        wr(2'b10, 64'h0000_0000_0000_00C1);
        wr(2'b10, 64'h0000_0000_0000_00C2);
        net_so = 1'b1; net_di = 64'hD1;
        tick();
        net_di = 64'hD2;
        tick();
        net_so = 1'b0;
        chk("pre_rst_ro", 64'(net_ro), 64'd0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("post_rst_ro", 64'(net_ro), 64'd1);
        chk("post_rst_si", 64'(net_si), 64'd0);
        chk("post_rst_do", net_do, 64'h0);
        peek(2'b01, "post_rst_in", 64'h0);
        peek(2'b11, "post_rst_out", 64'h0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_err);
        $finish;
    end

endmodule
